// File: rtl/alu_ops_pkg.sv
// Shared ALU operation encoding, branch-condition codes and sequencer state type.
// The ALU control decoder reuses these same constants.
package alu_ops_pkg;

    localparam logic [3:0] NO_OP     = 4'd0;
    localparam logic [3:0] ADD       = 4'd1;
    localparam logic [3:0] SUB       = 4'd2;
    localparam logic [3:0] AND_OP    = 4'd3;
    localparam logic [3:0] OR_OP     = 4'd4;
    localparam logic [3:0] SHIFT_L1  = 4'd5;
    localparam logic [3:0] XOR_OP    = 4'd6;
    localparam logic [3:0] SHIFT_R   = 4'd7;
    localparam logic [3:0] SHIFT_RA1 = 4'd8;
    localparam logic [3:0] SLT       = 4'd9;
    localparam logic [3:0] NOR_OP    = 4'd10;
    localparam logic [3:0] BEQ       = 4'd11;
    localparam logic [3:0] BNE       = 4'd12;
    localparam logic [3:0] BLE       = 4'd13;
    localparam logic [3:0] BGT       = 4'd14;
    localparam logic [3:0] LUI       = 4'd15;

    localparam logic [1:0] EQ = 2'b00;
    localparam logic [1:0] NE = 2'b01;
    localparam logic [1:0] LE = 2'b10;
    localparam logic [1:0] GT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_STEP1 = 3'd2,
        ST_STEP2 = 3'd3,
        ST_WB    = 3'd4
    } seq_state_e;

    function automatic logic is_multicycle(input logic [3:0] code);
        return (code == SHIFT_L1) || (code == SHIFT_R) ||
               (code == SHIFT_RA1) || (code == LUI);
    endfunction

    function automatic logic is_branch(input logic [3:0] code);
        return (code >= BEQ) && (code <= BGT);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decision from the decoder's branch outputs and ALU flags.
module branch_cond_eval
    import alu_ops_pkg::*;
(
    input  logic       i_uc_control,
    input  logic [1:0] i_uc_op,
    input  logic       i_eq,
    input  logic       i_gt,
    output logic       o_taken
);

    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (i_uc_op)
            EQ:      w_cond = i_eq;
            NE:      w_cond = !i_eq;
            LE:      w_cond = !i_gt;
            GT:      w_cond = i_gt;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_taken = i_uc_control & w_cond;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer: holds ALUOp and steps COUNTER for the registered ALU
// control decoder, then resolves the branch decision and ALUOut strobe in WB.
//
// state    | meaning
// ST_IDLE  | ready, ALUOp=NO_OP, COUNTER=0
// ST_ISSUE | decoder registers ALUOp, COUNTER=0 (shifter load for MC)
// ST_STEP1 | COUNTER=1, shifter operate (MC only)
// ST_STEP2 | COUNTER=2, shifter idle (MC only)
// ST_WB    | result valid: done, ALUOut strobe / branch decision, may accept
module alu_op_sequencer
    import alu_ops_pkg::*;
#(
    parameter int OPW = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic           UC_control,
    input  logic [1:0]     UC_op,
    input  logic           eq,
    input  logic           gt,
    output logic [OPW-1:0] ALUOp,
    output logic [CW-1:0]  COUNTER,
    output logic           ready,
    output logic           done,
    output logic           aluout_we,
    output logic           branch_taken
);

    seq_state_e     r_state;
    logic [OPW-1:0] r_aluop;
    logic [CW-1:0]  r_counter;
    logic           w_taken;
    logic           w_in_wb;
    logic           w_is_br;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_aluop   <= '0;
            r_counter <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_aluop <= op;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_multicycle(r_aluop)) begin
                        r_counter <= CW'(1);
                        r_state   <= ST_STEP1;
                    end else begin
                        r_state   <= ST_WB;
                    end
                end
                ST_STEP1: begin
                    r_counter <= CW'(2);
                    r_state   <= ST_STEP2;
                end
                ST_STEP2: begin
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    // COUNTER must be 0 again for the next ISSUE or IDLE
                    r_counter <= '0;
                    if (start) begin
                        r_aluop <= op;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_aluop <= OPW'(NO_OP);
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_aluop   <= '0;
                    r_counter <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    branch_cond_eval u_branch_cond_eval (
        .i_uc_control (UC_control),
        .i_uc_op      (UC_op),
        .i_eq         (eq),
        .i_gt         (gt),
        .o_taken      (w_taken)
    );

    assign w_in_wb      = (r_state == ST_WB);
    assign w_is_br      = is_branch(r_aluop);
    assign ALUOp        = r_aluop;
    assign COUNTER      = r_counter;
    assign ready        = (r_state == ST_IDLE) || w_in_wb;
    assign done         = w_in_wb;
    assign aluout_we    = w_in_wb & !w_is_br;
    assign branch_taken = w_in_wb & w_is_br & w_taken;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected WB results are queued at
// issue and compared whenever done is observed.
module tb_alu_op_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic       UC_control;
    logic [1:0] UC_op;
    logic       eq;
    logic       gt;
    logic [3:0] ALUOp;
    logic [1:0] COUNTER;
    logic       ready;
    logic       done;
    logic       aluout_we;
    logic       branch_taken;

    typedef struct {
        logic [3:0] op;
        logic       we;
        logic       bt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_op_sequencer #(.OPW(4), .CW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .UC_control   (UC_control),
        .UC_op        (UC_op),
        .eq           (eq),
        .gt           (gt),
        .ALUOp        (ALUOp),
        .COUNTER      (COUNTER),
        .ready        (ready),
        .done         (done),
        .aluout_we    (aluout_we),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic c, input logic [1:0] u,
                                   input logic e, input logic g);
        exp_t m;
        logic br;
        logic cnd;
        br = (o >= 4'd11) && (o <= 4'd14);
        case (u)
            2'b00:   cnd = e;
            2'b01:   cnd = !e;
            2'b10:   cnd = !g;
            default: cnd = g;
        endcase
        m.op = o;
        m.we = !br;
        m.bt = br & c & cnd;
        return m;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("wb_aluop", ALUOp, e.op);
                check_eq("wb_aluout_we", aluout_we, e.we);
                check_eq("wb_branch_taken", branch_taken, e.bt);
            end
        end else begin
            if (aluout_we || branch_taken)
                check_eq("strobe_without_done", {aluout_we, branch_taken}, 0);
        end
    end

    // Waits for ready, drives one accepted request, returns 1 ns into ISSUE.
    task automatic issue(input logic [3:0] o, input logic c, input logic [1:0] u,
                         input logic e, input logic g);
        int k = 0;
        @(negedge clk);
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ready) check_eq("ready_wait", 0, 1);
        op = o; UC_control = c; UC_op = u; eq = e; gt = g;
        start = 1'b1;
        sb_q.push_back(model(o, c, u, e, g));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 ns into ISSUE; counts cycles (ISSUE = 1) until done, returns at WB negedge.
    task automatic wait_done(input int exp_n, input string tag);
        int  n = 1;
        bit  seen = 0;
        while (n <= 20 && !seen) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        check_eq(tag, seen ? n : 99, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cnt_exp [4];
        logic       done_exp[4];
        cnt_exp = '{2'd0, 2'd1, 2'd2, 2'd2};
        done_exp = '{1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b0; start = 1'b0; op = 4'd0;
        UC_control = 1'b0; UC_op = 2'b00; eq = 1'b0; gt = 1'b0;
        #3;
        check_eq("rst_aluop", ALUOp, 0);
        check_eq("rst_counter", COUNTER, 0);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_we_bt", {aluout_we, branch_taken}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ADD: ALUOp held 2 cycles, COUNTER stays 0
        issue(4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("add_issue_aluop", ALUOp, 1);
        check_eq("add_issue_counter", COUNTER, 0);
        check_eq("add_issue_ready", ready, 0);
        wait_done(2, "add_latency");
        check_eq("add_wb_counter", COUNTER, 0);
        @(posedge clk); #1;
        check_eq("idle_aluop", ALUOp, 0);
        check_eq("idle_ready", ready, 1);

        // SHIFT_R: COUNTER 0,1,2,2 and done only in WB
        issue(4'd7, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("shr_counter_%0d", i), COUNTER, cnt_exp[i]);
            check_eq($sformatf("shr_done_%0d", i), done, done_exp[i]);
            check_eq($sformatf("shr_aluop_%0d", i), ALUOp, 7);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check_eq("shr_idle_counter", COUNTER, 0);

        issue(4'd7, 1'b0, 2'b00, 1'b0, 1'b0);
        wait_done(4, "mc_latency");

        // Branches
        issue(4'd12, 1'b1, 2'b01, 1'b0, 1'b0);
        wait_done(2, "bne_ne_latency");
        issue(4'd12, 1'b1, 2'b01, 1'b1, 1'b0);
        wait_done(2, "bne_eq_latency");
        issue(4'd14, 1'b1, 2'b11, 1'b0, 1'b1);
        wait_done(2, "bgt_latency");
        issue(4'd13, 1'b1, 2'b10, 1'b0, 1'b1);
        wait_done(2, "ble_latency");
        issue(4'd13, 1'b1, 2'b10, 1'b1, 1'b0);
        wait_done(2, "ble_taken_latency");
        issue(4'd11, 1'b1, 2'b00, 1'b1, 1'b0);
        wait_done(2, "beq_latency");
        issue(4'd12, 1'b0, 2'b01, 1'b0, 1'b0);
        wait_done(2, "bne_noctl_latency");

        // SHIFT_L1: start pulsed in STEP1 is ignored; start held in WB chains
        issue(4'd5, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_eq("step1_ready", ready, 0);
        op = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("step2_aluop_held", ALUOp, 5);
        check_eq("step2_counter", COUNTER, 2);
        op = 4'd2; start = 1'b1;
        sb_q.push_back(model(4'd2, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk); #1;
        check_eq("wb_done", done, 1);
        check_eq("wb_counter_sat", COUNTER, 2);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("b2b_aluop", ALUOp, 2);
        check_eq("b2b_counter", COUNTER, 0);
        check_eq("b2b_ready", ready, 0);
        wait_done(2, "b2b_latency");

        // LUI aborted by reset in STEP2
        issue(4'd15, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("lui_step2_counter", COUNTER, 2);
        #1;
        reset = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check_eq("abort_aluop", ALUOp, 0);
        check_eq("abort_counter", COUNTER, 0);
        check_eq("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_hold_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("release_ready", ready, 1);
        op = 4'd1; start = 1'b1;
        sb_q.push_back(model(4'd1, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("first_accept_aluop", ALUOp, 1);
        wait_done(2, "post_reset_latency");

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
